// File: rtl/app_ctrl_pkg.sv
// Shared types and helpers for the application controller.
//   state_e  : controller FSM states
//   mode_e   : LED pattern selection, latched when a run starts
//   cnt_width: bits needed to hold the values 0..max_val (never less than 1)
package app_ctrl_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RUNNING = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/go_debouncer.sv
// Push-button front end: 2-flop synchroniser, debounce counter and a
// one-cycle pulse on each rising edge of the debounced level.
// The block is generic and can be reused for any other shell button.
//   clock    : system clock
//   reset    : synchronous, active-high
//   button   : raw asynchronous button level
//   go_pulse : registered one-cycle pulse on each debounced rising edge
module go_debouncer
  import app_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic go_pulse
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  // The counter only advances while the synchronised input disagrees with
  // the debounced level, so any agreeing sample restarts the wait.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      level    <= 1'b0;
      level_q  <= 1'b0;
      go_pulse <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= button;
      sync2    <= sync1;
      level_q  <= level;
      go_pulse <= level & ~level_q;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/application_controller.sv
// Application start/stop controller with an LED pattern generator.
// A debounced "go" press starts a run; the stop level, or the optional
// run timeout, ends it. While running, the LED bank shows one of four
// patterns that advance once per prescaler tick.
//   clock, reset       : system clock, synchronous active-high reset
//   application_go     : raw push button (debounced internally)
//   application_stop   : stop request level (synchronised, not debounced)
//   mode               : pattern select, sampled on run start
//   application_active : high while RUNNING
//   leds               : LED drive, zero when IDLE
//   run_done           : one-cycle pulse when a run times out
module application_controller
  import app_ctrl_pkg::*;
#(
  parameter int NUM_LEDS        = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_CYCLES     = 12_500_000,
  parameter int RUN_TICKS       = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                application_go,
  input  logic                application_stop,
  input  logic [1:0]          mode,
  output logic                application_active,
  output logic [NUM_LEDS-1:0] leds,
  output logic                run_done
);

  localparam int            PW         = cnt_width(TICK_CYCLES - 1);
  localparam int            TW         = cnt_width(RUN_TICKS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'((RUN_TICKS == 0) ? 0 : RUN_TICKS - 1);
  localparam logic [TW-1:0] TICK_MAX   = TW'(RUN_TICKS);

  function automatic logic [NUM_LEDS-1:0] init_pattern(input mode_e m);
    case (m)
      MODE_CHASE, MODE_COUNT: init_pattern = NUM_LEDS'(1);
      default:                init_pattern = '1;
    endcase
  endfunction

  function automatic logic [NUM_LEDS-1:0] next_pattern(input mode_e m,
                                                       input logic [NUM_LEDS-1:0] p);
    case (m)
      MODE_BLINK: next_pattern = ~p;
      MODE_CHASE: next_pattern = {p[NUM_LEDS-2:0], p[NUM_LEDS-1]};
      MODE_COUNT: next_pattern = p + 1'b1;
      default:    next_pattern = p;
    endcase
  endfunction

  logic go_pulse;
  logic stop_meta;
  logic stop_s;

  go_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_go_debouncer (
    .clock   (clock),
    .reset   (reset),
    .button  (application_go),
    .go_pulse(go_pulse)
  );

  state_e              state_q,   state_n;
  mode_e               mode_q,    mode_n;
  logic [PW-1:0]       presc_q,   presc_n;
  logic [TW-1:0]       tick_q,    tick_n;
  logic [NUM_LEDS-1:0] pattern_q, pattern_n;
  logic [NUM_LEDS-1:0] leds_n;
  logic                done_n;
  logic                tick;
  logic                expire;

  assign tick               = (presc_q == PRESC_LAST);
  assign expire             = (RUN_TICKS != 0) && tick && (tick_q == TICK_LAST);
  assign application_active = (state_q == RUNNING);

  always_comb begin
    state_n   = state_q;
    mode_n    = mode_q;
    presc_n   = presc_q;
    tick_n    = tick_q;
    pattern_n = pattern_q;
    done_n    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go_pulse && !stop_s) begin
          state_n   = RUNNING;
          mode_n    = mode_e'(mode);
          presc_n   = '0;
          tick_n    = '0;
          pattern_n = init_pattern(mode_e'(mode));
        end
      end
      RUNNING: begin
        // Stop is checked first so it wins over a coinciding timeout.
        if (stop_s) begin
          state_n = IDLE;
        end else if (expire) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          presc_n = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            if (tick_q != TICK_MAX) tick_n = tick_q + 1'b1;
            pattern_n = next_pattern(mode_q, pattern_q);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    leds_n = (state_n == RUNNING) ? pattern_n : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stop_meta <= 1'b0;
      stop_s    <= 1'b0;
      state_q   <= IDLE;
      mode_q    <= MODE_SOLID;
      presc_q   <= '0;
      tick_q    <= '0;
      pattern_q <= '0;
      leds      <= '0;
      run_done  <= 1'b0;
    end else begin
      stop_meta <= application_stop;
      stop_s    <= stop_meta;
      state_q   <= state_n;
      mode_q    <= mode_n;
      presc_q   <= presc_n;
      tick_q    <= tick_n;
      pattern_q <= pattern_n;
      leds      <= leds_n;
      run_done  <= done_n;
    end
  end

endmodule

// File: tb/tb_application_controller.sv
// Bench for application_controller: two instances (RUN_TICKS=5 and
// RUN_TICKS=0) share the same stimulus. Every cycle both are compared to a
// reference model that works from elapsed cycles since run start; a table
// of hand-derived vectors and a few directed sequences add fixed checks.
module tb_application_controller;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int TC = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         go    = 1'b0;
  logic         stop  = 1'b0;
  logic [1:0]   mode  = 2'd0;
  logic         act5, done5, act0, done0;
  logic [N-1:0] leds5, leds0;

  always #5 clock = ~clock;

  application_controller #(.NUM_LEDS(N), .DEBOUNCE_CYCLES(DB), .TICK_CYCLES(TC), .RUN_TICKS(5)) dut (
    .clock(clock), .reset(reset), .application_go(go), .application_stop(stop), .mode(mode),
    .application_active(act5), .leds(leds5), .run_done(done5));

  application_controller #(.NUM_LEDS(N), .DEBOUNCE_CYCLES(DB), .TICK_CYCLES(TC), .RUN_TICKS(0)) dut0 (
    .clock(clock), .reset(reset), .application_go(go), .application_stop(stop), .mode(mode),
    .application_active(act0), .leds(leds0), .run_done(done0));

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int           cyc = 0;
  logic         gq[2], sq[2], rh[2];
  logic         win[DB];
  logic         deb;
  int           rt[2];
  logic         m_run[2], m_done[2];
  int           m_start[2];
  logic [1:0]   m_mode[2];
  logic [N-1:0] m_leds[2];

  function automatic logic [N-1:0] pat(input logic [1:0] m, input int t);
    case (m)
      2'd0:    pat = '1;
      2'd1:    pat = (t % 2 == 0) ? '1 : '0;
      2'd2:    pat = N'(1) << (t % N);
      default: pat = N'(t + 1);
    endcase
  endfunction

  task automatic model_step();
    logic pulse, ss, sg, flip;
    if (reset) begin
      gq = '{1'b0, 1'b0}; sq = '{1'b0, 1'b0}; rh = '{1'b0, 1'b0};
      for (int j = 0; j < DB; j++) win[j] = 1'b0;
      deb = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_run[i] = 1'b0; m_done[i] = 1'b0; m_leds[i] = '0;
      end
      cyc++;
      return;
    end
    pulse = rh[0]; ss = sq[0]; sg = gq[0];
    gq[0] = gq[1]; gq[1] = go;
    sq[0] = sq[1]; sq[1] = stop;
    // debounced level flips once the last DB synchronised samples all differ
    for (int j = 0; j < DB - 1; j++) win[j] = win[j + 1];
    win[DB - 1] = sg;
    flip = 1'b1;
    for (int j = 0; j < DB; j++) if (win[j] == deb) flip = 1'b0;
    rh[0] = rh[1];
    rh[1] = flip && !deb;
    if (flip) deb = ~deb;
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (!m_run[i]) begin
        if (pulse && !ss) begin
          m_run[i] = 1'b1; m_start[i] = cyc; m_mode[i] = mode;
        end
      end else if (ss) begin
        m_run[i] = 1'b0;
      end else if (rt[i] != 0 && cyc - m_start[i] == rt[i] * TC) begin
        m_run[i] = 1'b0; m_done[i] = 1'b1;
      end
      m_leds[i] = m_run[i] ? pat(m_mode[i], (cyc - m_start[i]) / TC) : '0;
    end
    cyc++;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic compare();
    chk("act5",  32'(act5),  32'(m_run[0]));
    chk("leds5", 32'(leds5), 32'(m_leds[0]));
    chk("done5", 32'(done5), 32'(m_done[0]));
    chk("act0",  32'(act0),  32'(m_run[1]));
    chk("leds0", 32'(leds0), 32'(m_leds[1]));
    chk("done0", 32'(done0), 32'(m_done[1]));
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    @(negedge clock);
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b1; go = 1'b0; stop = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic wait_active(input string nm);
    bit ok = 1'b0;
    for (int c = 0; c < 30 && !ok; c++) begin
      step();
      if (act5) ok = 1'b1;
    end
    chk({nm, "_start_timeout"}, 32'(ok), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]   mode;
    int           k;       // cycles after the first active cycle
    logic [N-1:0] leds5;
    logic         act5;
    logic         done5;
    logic [N-1:0] leds0;
  } vec_t;

  vec_t vt[$];

  initial begin
    int n;
    bit seen;
    int hold;

    rt[0] = 5; rt[1] = 0;
    vt.push_back('{2'd0,  0, 4'b1111, 1'b1, 1'b0, 4'b1111});
    vt.push_back('{2'd0, 14, 4'b1111, 1'b1, 1'b0, 4'b1111});
    vt.push_back('{2'd0, 15, 4'b0000, 1'b0, 1'b1, 4'b1111});
    vt.push_back('{2'd0, 16, 4'b0000, 1'b0, 1'b0, 4'b1111});
    vt.push_back('{2'd1,  2, 4'b1111, 1'b1, 1'b0, 4'b1111});
    vt.push_back('{2'd1,  3, 4'b0000, 1'b1, 1'b0, 4'b0000});
    vt.push_back('{2'd1,  7, 4'b1111, 1'b1, 1'b0, 4'b1111});
    vt.push_back('{2'd2,  0, 4'b0001, 1'b1, 1'b0, 4'b0001});
    vt.push_back('{2'd2,  3, 4'b0010, 1'b1, 1'b0, 4'b0010});
    vt.push_back('{2'd2,  6, 4'b0100, 1'b1, 1'b0, 4'b0100});
    vt.push_back('{2'd2,  9, 4'b1000, 1'b1, 1'b0, 4'b1000});
    vt.push_back('{2'd2, 12, 4'b0001, 1'b1, 1'b0, 4'b0001});
    vt.push_back('{2'd2, 15, 4'b0000, 1'b0, 1'b1, 4'b0010});
    vt.push_back('{2'd3,  0, 4'b0001, 1'b1, 1'b0, 4'b0001});
    vt.push_back('{2'd3, 15, 4'b0000, 1'b0, 1'b1, 4'b0110});
    vt.push_back('{2'd3, 44, 4'b0000, 1'b0, 1'b0, 4'b1111});
    vt.push_back('{2'd3, 45, 4'b0000, 1'b0, 1'b0, 4'b0000});
    vt.push_back('{2'd3, 48, 4'b0000, 1'b0, 1'b0, 4'b0001});

    @(negedge clock);
    do_reset();

    // Debounce latency: raw go high before edge 0, active after edge 7.
    go = 1'b1; mode = 2'd0; n = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (act5) break;
      n++;
    end
    chk("go_latency", 32'(n), 32'd7);
    chk("go_first_leds", 32'(leds5), 32'hF);

    // A 3-cycle glitch must not start a run.
    do_reset();
    go = 1'b1;
    for (int c = 0; c < 3; c++) step();
    go = 1'b0; seen = 1'b0;
    for (int c = 0; c < 15; c++) begin step(); if (act5) seen = 1'b1; end
    chk("glitch_ignored", 32'(seen), 32'd0);

    // Table of fixed vectors.
    for (int i = 0; i < vt.size(); i++) begin
      do_reset();
      mode = vt[i].mode; go = 1'b1;
      wait_active("vec");
      for (int c = 0; c < vt[i].k; c++) step();
      chk($sformatf("vec%0d_leds5", i), 32'(leds5), 32'(vt[i].leds5));
      chk($sformatf("vec%0d_act5",  i), 32'(act5),  32'(vt[i].act5));
      chk($sformatf("vec%0d_done5", i), 32'(done5), 32'(vt[i].done5));
      chk($sformatf("vec%0d_leds0", i), 32'(leds0), 32'(vt[i].leds0));
    end

    // Stop lands on the expiring tick: stop wins, no run_done.
    do_reset();
    mode = 2'd2; go = 1'b1;
    wait_active("stopx");
    seen = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 13) stop = 1'b1;
      step();
      if (done5) seen = 1'b1;
    end
    chk("stop_vs_expire_done", 32'(seen), 32'd0);
    chk("stop_vs_expire_act", 32'(act5), 32'd0);
    // Fresh press while stop is held keeps the controller idle.
    go = 1'b0;
    for (int c = 0; c < 8; c++) step();
    go = 1'b1; seen = 1'b0;
    for (int c = 0; c < 15; c++) begin step(); if (act5) seen = 1'b1; end
    chk("go_with_stop_idle", 32'(seen), 32'd0);
    stop = 1'b0;

    // Second press and mode change while running are ignored.
    do_reset();
    mode = 2'd2; go = 1'b1;
    wait_active("ign");
    for (int c = 1; c <= 15; c++) begin
      if (c == 1) go = 1'b0;
      if (c == 2) mode = 2'd1;
      if (c == 7) go = 1'b1;
      step();
      if (c == 9)  chk("ign_leds_k9", 32'(leds5), 32'h8);
      if (c == 12) chk("ign_leds_k12", 32'(leds5), 32'h1);
    end
    chk("ign_done", 32'(done5), 32'd1);

    // Reset during tick 2 aborts at once; a held go restarts from scratch.
    do_reset();
    mode = 2'd2; go = 1'b1;
    wait_active("rst");
    for (int c = 1; c <= 5; c++) step();
    reset = 1'b1;
    step();
    chk("rst_act", 32'(act5), 32'd0);
    chk("rst_leds", 32'(leds5), 32'd0);
    chk("rst_done", 32'(done5), 32'd0);
    reset = 1'b0;
    wait_active("rst_restart");
    chk("rst_restart_leds", 32'(leds5), 32'h1);

    // Random stimulus against the model.
    do_reset();
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        go   = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 12);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 99) < 3) stop = ~stop;
      mode  = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/application_controller.md
Name: application_controller

Overview:
- Parametrised successor to the single-shot application starter. Debounces the user "go" button, runs a start/stop state machine with an optional run timeout, and drives an N-wide LED bank in one of four patterns.
- Sits inside the application shell between the push-button/switch UI and the board LEDs, in the fpga_clock domain.
- Supplies application_active to the UI "program active" indicator.

Parameters:
NUM_LEDS, 4, width of leds output; legal range 2..16.
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before the debounced go level changes; must be >= 2.
TICK_CYCLES, 12_500_000, clock cycles per pattern tick; must be >= 2.
RUN_TICKS, 0, ticks before automatic stop; 0 means run until application_stop.

Ports:
clock  in  1  system clock (fpga_clock).
reset  in  1  synchronous, active-high.
application_go  in  1  raw asynchronous push button, active-high.
application_stop  in  1  asynchronous stop request, level, active-high.
mode  in  2  pattern select (0 solid, 1 blink, 2 chase, 3 count); sampled on run start.
application_active  out  1  high while RUNNING.
leds  out  NUM_LEDS  LED drive, active-high.
run_done  out  1  one-cycle pulse on timeout completion.

Behaviour:
- Reset is synchronous and active-high on clock. All of the following reset to 0: state (IDLE), synchronisers, debounce counter, debounced level, prescaler, tick counter, application_active, leds, run_done.
- Reset mid-run aborts immediately. No run_done pulse is produced.
- Inputs: application_go and application_stop each pass through a 2-flop synchroniser.
- Debounce:
  - The counter clears whenever the synchronised go level equals the debounced level.
  - Otherwise it increments.
  - At DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
- go_pulse is the rising edge of the debounced level, one cycle wide. A clean raw high edge at cycle 0 yields go_pulse at cycle DEBOUNCE_CYCLES+2. Glitches shorter than DEBOUNCE_CYCLES are ignored. Falling edges produce no pulse.
- stop_s is the synchronised stop level. It is not debounced.
- FSM states: IDLE, RUNNING. All outputs are registered.
- IDLE:
  - go_pulse and not stop_s → RUNNING.
  - On entry: latch mode, clear prescaler and tick counter, load the initial pattern.
  - go_pulse with stop_s asserted → remain IDLE.
- RUNNING:
  - stop_s → IDLE; run_done stays 0.
  - Else, if RUN_TICKS != 0 and a tick occurs with tick counter == RUN_TICKS-1 → IDLE with run_done=1 for that one cycle.
  - If stop and expiry coincide, stop wins and run_done=0.
  - go_pulse while RUNNING is ignored; it does not restart the run.
  - Mode changes while RUNNING are ignored until the next start.
- Prescaler: counts 0..TICK_CYCLES-1 while RUNNING. Tick is asserted when it reaches TICK_CYCLES-1, after which it wraps to 0. The first tick occurs TICK_CYCLES cycles after the entry cycle.
- Tick counter: width clog2(RUN_TICKS+1), minimum 1. Increments on each tick and saturates; it is unused when RUN_TICKS==0.
- Patterns (initial value → update on each tick):
  - solid: all ones → unchanged.
  - blink: all ones → bitwise invert.
  - chase: bit0 only → rotate left; MSB wraps to bit0.
  - count: 1 → +1 modulo 2^NUM_LEDS; wraps through 0.
- application_active=1 exactly while in RUNNING, including the entry cycle.
- leds=0 in IDLE; leds=pattern register in RUNNING.

Decomposition:
- Package app_ctrl_pkg:
  - state enum {IDLE, RUNNING};
  - mode enum {MODE_SOLID=0, MODE_BLINK=1, MODE_CHASE=2, MODE_COUNT=3};
  - width helper function for counters.
- Sub-module go_debouncer (parameter DEBOUNCE_CYCLES): synchroniser, debounce counter and rising-edge pulse. It is reusable for other shell buttons.
- application_controller holds the FSM, prescaler, run timer and pattern generator.

Test Plan (NUM_LEDS=4, DEBOUNCE_CYCLES=4, TICK_CYCLES=3, RUN_TICKS=5 unless noted):
- Debounce: go high at cycle 0 and held → go_pulse at cycle 6, application_active=1 at cycle 7, leds=4'b1111 (mode 0). A 3-cycle go glitch → no activation.
- Chase timeout: mode=2, start → leds 0001, 0010, 0100, 1000, 0001 every 3 cycles. On the 5th tick: IDLE, run_done=1 for exactly one cycle, leds=0, application_active=0.
- Blink/count: mode=1 → leds alternate 1111/0000 per tick. mode=3 with RUN_TICKS=0 → 1,2,...,15,0,1 with no run_done.
- Stop precedence: stop asserted so that stop_s coincides with the expiring tick → IDLE with run_done=0. Go held with stop high → remains IDLE.
- Ignored inputs: second go press and a mode change while RUNNING → pattern and timer unaffected, mode unchanged.
- Reset mid-run: reset during tick 2 → next cycle all outputs are 0 and the state is IDLE. A fresh go restarts with the initial pattern.
